// File: rtl/apu_sample_queue_if.sv
// Sample-path bundle between the register block / audio output block and the sample queue.
// The master drives the write and consume strobes; the slave returns the presented sample and occupancy.
interface apu_sample_queue_if #(
   parameter int W     = 32,
   parameter int DEPTH = 8
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic          push;
   logic [W-1:0]  push_data;
   logic          sample_rdy;
   logic [W-1:0]  sample;
   logic [LW-1:0] level;
   logic          full;

   modport master (
      output push, push_data, sample_rdy,
      input  sample, level, full
   );

   modport slave (
      input  push, push_data, sample_rdy,
      output sample, level, full
   );
endinterface

// File: rtl/apu_sample_queue.sv
// APU sample queue: circular FIFO feeding a held output sample register, with sticky
// overflow/underflow flags and a level-threshold refill interrupt.
module apu_sample_queue #(
   parameter int DEPTH = 8,
   parameter int W     = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       en,
   input  logic                       underflow_zero,
   input  logic [$clog2(DEPTH):0]     irq_thresh,
   input  logic                       clr_flags,
   output logic                       overflow,
   output logic                       underflow,
   output logic                       irq,
   apu_sample_queue_if.slave          bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;
   logic [PW-1:0] level;
   logic [W-1:0]  sample_q;
   logic          overflow_q;
   logic          underflow_q;

   logic          full;
   logic          empty;
   logic          consume;
   logic          pop;
   logic          under_ev;
   logic          push_req;
   logic          push_ok;
   logic          ovf_ev;

   // Occupancy comes only from registered pointers; the extra pointer bit
   // keeps full and empty distinct across wrap.
   assign level    = wptr - rptr;
   assign full     = (level == DEPTH_P);
   assign empty    = (level == '0);

   assign consume  = en & bus.sample_rdy;
   assign pop      = consume & ~empty;
   assign under_ev = consume & empty;

   // A full queue still takes a push when the same edge frees a slot.
   assign push_req = en & bus.push;
   assign push_ok  = push_req & (~full | pop);
   assign ovf_ev   = push_req & ~push_ok;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr     <= '0;
         rptr     <= '0;
         sample_q <= '0;
      end else if (!en) begin
         wptr     <= '0;
         rptr     <= '0;
         sample_q <= '0;
      end else begin
         if (push_ok)
            wptr <= wptr + 1'b1;
         if (pop) begin
            rptr     <= rptr + 1'b1;
            sample_q <= mem[rptr[AW-1:0]];
         end else if (under_ev && underflow_zero) begin
            sample_q <= '0;
         end
      end
   end

   // Storage needs no reset: pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wptr[AW-1:0]] <= bus.push_data;
   end

   // Flags survive en low; a same-cycle set beats the clear strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= ovf_ev   | (overflow_q  & ~clr_flags);
         underflow_q <= under_ev | (underflow_q & ~clr_flags);
      end
   end

   assign bus.sample = sample_q;
   assign bus.level  = level;
   assign bus.full   = full;
   assign overflow   = overflow_q;
   assign underflow  = underflow_q;
   assign irq        = en & (level <= irq_thresh);

endmodule

// File: tb/tb_apu_sample_queue.sv
// Directed bench for apu_sample_queue: vector table for single-cycle behaviour,
// hand sequences for fill/overflow, enable flush, pointer wrap and mid-run reset.
module tb_apu_sample_queue;

   localparam int W     = 32;
   localparam int DEPTH = 8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic       underflow_zero;
   logic [3:0] irq_thresh;
   logic       clr_flags;
   logic       overflow;
   logic       underflow;
   logic       irq;

   int n_vec = 0;
   int n_bad = 0;

   apu_sample_queue_if #(.W(W), .DEPTH(DEPTH)) bus ();

   apu_sample_queue #(.DEPTH(DEPTH), .W(W)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .en             (en),
      .underflow_zero (underflow_zero),
      .irq_thresh     (irq_thresh),
      .clr_flags      (clr_flags),
      .overflow       (overflow),
      .underflow      (underflow),
      .irq            (irq),
      .bus            (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        en;
      logic        push;
      logic [31:0] data;
      logic        rdy;
      logic        uz;
      logic        clr;
      logic [31:0] x_sample;
      logic [3:0]  x_level;
      logic        x_full;
      logic        x_ovf;
      logic        x_unf;
      logic        x_irq;
   } vec_t;

   vec_t vecs [16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic p, input logic [31:0] d, input logic r);
      bus.push       = p;
      bus.push_data  = d;
      bus.sample_rdy = r;
   endtask

   logic [31:0] model_q [$];
   logic [31:0] exp_v;

   initial begin
      // en push data rdy uz clr | sample level full ovf unf irq   (irq_thresh = 2)
      vecs[0]  = '{1, 1, 32'h11112222, 0, 0, 0, 32'h00000000, 1, 0, 0, 0, 1};
      vecs[1]  = '{1, 1, 32'h33334444, 0, 0, 0, 32'h00000000, 2, 0, 0, 0, 1};
      vecs[2]  = '{1, 0, 32'h0,        1, 0, 0, 32'h11112222, 1, 0, 0, 0, 1};
      vecs[3]  = '{1, 0, 32'h0,        1, 0, 0, 32'h33334444, 0, 0, 0, 0, 1};
      vecs[4]  = '{1, 0, 32'h0,        1, 0, 0, 32'h33334444, 0, 0, 0, 1, 1};
      vecs[5]  = '{1, 0, 32'h0,        1, 1, 0, 32'h00000000, 0, 0, 0, 1, 1};
      vecs[6]  = '{1, 0, 32'h0,        0, 0, 1, 32'h00000000, 0, 0, 0, 0, 1};
      vecs[7]  = '{1, 1, 32'h5A5A5A5A, 1, 0, 0, 32'h00000000, 1, 0, 0, 1, 1};
      vecs[8]  = '{1, 0, 32'h0,        1, 0, 0, 32'h5A5A5A5A, 0, 0, 0, 1, 1};
      vecs[9]  = '{1, 0, 32'h0,        1, 0, 1, 32'h5A5A5A5A, 0, 0, 0, 1, 1};
      vecs[10] = '{1, 0, 32'h0,        0, 0, 1, 32'h5A5A5A5A, 0, 0, 0, 0, 1};
      vecs[11] = '{1, 1, 32'h0000ABCD, 0, 0, 0, 32'h5A5A5A5A, 1, 0, 0, 0, 1};
      vecs[12] = '{1, 0, 32'h0,        1, 0, 0, 32'h0000ABCD, 0, 0, 0, 0, 1};
      vecs[13] = '{1, 0, 32'h0,        1, 0, 0, 32'h0000ABCD, 0, 0, 0, 1, 1};
      vecs[14] = '{1, 0, 32'h0,        1, 1, 0, 32'h00000000, 0, 0, 0, 1, 1};
      vecs[15] = '{1, 0, 32'h0,        0, 0, 1, 32'h00000000, 0, 0, 0, 0, 1};

      rst_n          = 1'b0;
      en             = 1'b0;
      underflow_zero = 1'b0;
      irq_thresh     = 4'd2;
      clr_flags      = 1'b0;
      drive(0, 32'h0, 0);
      #22;
      chk("reset_level", 32'(bus.level), 32'd0);
      chk("reset_full",  32'(bus.full),  32'd0);
      chk("reset_irq",   32'(irq),       32'd0);
      chk("reset_sample", bus.sample,    32'd0);
      chk("reset_ovf",   32'(overflow),  32'd0);
      chk("reset_unf",   32'(underflow), 32'd0);
      rst_n = 1'b1;
      tick();

      foreach (vecs[i]) begin
         en             = vecs[i].en;
         underflow_zero = vecs[i].uz;
         clr_flags      = vecs[i].clr;
         drive(vecs[i].push, vecs[i].data, vecs[i].rdy);
         tick();
         chk($sformatf("v%0d_sample", i), bus.sample, vecs[i].x_sample);
         chk($sformatf("v%0d_level", i), 32'(bus.level), 32'(vecs[i].x_level));
         chk($sformatf("v%0d_full", i), 32'(bus.full), 32'(vecs[i].x_full));
         chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vecs[i].x_ovf));
         chk($sformatf("v%0d_unf", i), 32'(underflow), 32'(vecs[i].x_unf));
         chk($sformatf("v%0d_irq", i), 32'(irq), 32'(vecs[i].x_irq));
      end
      clr_flags      = 1'b0;
      underflow_zero = 1'b0;
      drive(0, 32'h0, 0);

      // Overfill: ninth push dropped
      for (int i = 0; i < 9; i++) begin
         drive(1, 32'h100 + i, 0);
         tick();
      end
      drive(0, 32'h0, 0);
      chk("fill_level", 32'(bus.level), 32'd8);
      chk("fill_full",  32'(bus.full),  32'd1);
      chk("fill_ovf",   32'(overflow),  32'd1);
      chk("fill_irq",   32'(irq),       32'd0);
      clr_flags = 1'b1;
      tick();
      clr_flags = 1'b0;
      chk("clr_ovf",    32'(overflow),  32'd0);

      // Full queue: push + consume in the same cycle is accepted
      drive(1, 32'h0000BEEF, 1);
      tick();
      drive(0, 32'h0, 0);
      chk("fullpp_level",  32'(bus.level), 32'd8);
      chk("fullpp_ovf",    32'(overflow),  32'd0);
      chk("fullpp_sample", bus.sample,     32'h100);
      irq_thresh = 4'd8;
      #1;
      chk("thresh8_irq", 32'(irq), 32'd1);
      irq_thresh = 4'd7;
      #1;
      chk("thresh7_irq", 32'(irq), 32'd0);
      irq_thresh = 4'd2;
      for (int i = 1; i <= 8; i++) begin
         exp_v = (i == 8) ? 32'h0000BEEF : 32'h100 + i;
         drive(0, 32'h0, 1);
         tick();
         chk($sformatf("drain%0d_sample", i), bus.sample, exp_v);
      end
      drive(0, 32'h0, 0);
      chk("drain_level", 32'(bus.level), 32'd0);

      // Enable flush: set underflow, queue 5, drop en (with a push that must be ignored)
      underflow_zero = 1'b1;
      drive(0, 32'h0, 1);
      tick();
      underflow_zero = 1'b0;
      chk("pre_unf", 32'(underflow), 32'd1);
      for (int i = 0; i < 5; i++) begin
         drive(1, 32'hC000 + i, 0);
         tick();
      end
      drive(0, 32'h0, 0);
      chk("pre_level", 32'(bus.level), 32'd5);
      tick();
      en = 1'b0;
      drive(1, 32'hDEADBEEF, 1);
      tick();
      chk("flush_level",  32'(bus.level), 32'd0);
      chk("flush_sample", bus.sample,     32'd0);
      chk("flush_irq",    32'(irq),       32'd0);
      chk("flush_unf",    32'(underflow), 32'd1);
      chk("flush_ovf",    32'(overflow),  32'd0);
      drive(0, 32'h0, 0);
      en = 1'b1;

      // Streaming across pointer wrap with three entries in flight
      model_q.delete();
      for (int i = 0; i < 3; i++) begin
         drive(1, 32'hA0000000 + i, 0);
         model_q.push_back(32'hA0000000 + i);
         tick();
      end
      for (int i = 3; i < 23; i++) begin
         drive(1, 32'hA0000000 + i, 1);
         model_q.push_back(32'hA0000000 + i);
         exp_v = model_q.pop_front();
         tick();
         chk($sformatf("wrap%0d_sample", i), bus.sample, exp_v);
         chk($sformatf("wrap%0d_level", i), 32'(bus.level), 32'd3);
      end
      drive(0, 32'h0, 0);
      chk("wrap_unf", 32'(underflow), 32'd1);

      // Reset mid-operation discards everything
      rst_n = 1'b0;
      #1;
      chk("midrst_level",  32'(bus.level), 32'd0);
      chk("midrst_sample", bus.sample,     32'd0);
      chk("midrst_unf",    32'(underflow), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      drive(0, 32'h0, 1);
      tick();
      drive(0, 32'h0, 0);
      chk("postrst_sample", bus.sample,     32'd0);
      chk("postrst_unf",    32'(underflow), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/apu_sample_queue.md
APU_SAMPLE_QUEUE -- requirements
Module: apu_sample_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning number of FIFO entries (power of 2, >= 2).
REQ-002 SHALL have parameter W, default 32, meaning sample width ({left[15:0], right[15:0]}).
REQ-003 SHALL have port clk  in  1  sole clock.
REQ-004 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port en  in  1  queue enable; low = flush and idle.
REQ-006 SHALL have port push  in  1  one-cycle write strobe from the register block.
REQ-007 SHALL have port push_data  in  W  sample written on push.
REQ-008 SHALL have port underflow_zero  in  1  underflow policy: 1 = output zero, 0 = repeat last sample.
REQ-009 SHALL have port irq_thresh  in  log2(DEPTH)+1  level at or below which irq asserts.
REQ-010 SHALL have port clr_flags  in  1  one-cycle strobe clearing sticky flags.
REQ-011 SHALL have port sample  out  W  current sample presented to the audio output block.
REQ-012 SHALL have port sample_rdy  in  1  one-cycle consume strobe from the audio output block.
REQ-013 SHALL have port level  out  log2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
REQ-014 SHALL have port full  out  1  level == DEPTH.
REQ-015 SHALL have port overflow  out  1  sticky: a push was dropped.
REQ-016 SHALL have port underflow  out  1  sticky: a consume found the FIFO empty.
REQ-017 SHALL have port irq  out  1  refill request, level-sensitive.

Function
REQ-018 SHALL store samples in a DEPTH-entry circular FIFO with read/write pointers of log2(DEPTH)+1 bits; level = wptr - rptr; full and level SHALL be registered-pointer-derived (no input-to-output combinational path).
REQ-019 SHALL hold sample in a register, separate from the FIFO, stable between sample_rdy strobes.
REQ-020 SHALL, on a clock edge with en && sample_rdy && level != 0, load sample from the FIFO head and advance rptr; the new sample is visible the cycle after the strobe.
REQ-021 SHALL, on en && sample_rdy && level == 0, set underflow and load sample with 0 if underflow_zero else retain its value.
REQ-022 SHALL accept push when en && (!full || (sample_rdy && level != 0)): write push_data at wptr, advance wptr.
REQ-023 SHALL, on en && push not accepted, drop push_data, leave pointers unchanged, set overflow.
REQ-024 SHALL, on push and sample_rdy in the same cycle with level == 0, write push_data into the FIFO (no bypass to sample) and flag underflow; level becomes 1.
REQ-025 SHALL ignore push and sample_rdy while en is low; no flag update from them.
REQ-026 SHALL, while en is low, hold rptr = wptr = 0, level = 0, sample = 0; sticky flags SHALL be retained.
REQ-027 SHALL clear overflow and underflow on clr_flags; a set event in the same cycle SHALL win (flag stays 1).
REQ-028 SHALL drive irq = en && (level <= irq_thresh), registered-signal-derived; irq_thresh >= DEPTH keeps irq high while enabled.
REQ-029 SHALL wrap pointers modulo 2*DEPTH without disturbing level across wrap.

Reset
REQ-030 SHALL, on rst_n low, asynchronously clear pointers, sample, overflow, underflow; hence level = 0, full = 0, irq = 0, sample = 0.
REQ-031 SHALL, on reset mid-operation, discard all queued samples; no partial state survives.

Verification
REQ-032 Reset then en=1, irq_thresh=2: push 0x11112222, 0x33334444 -> level 2, irq 1, sample 0; sample_rdy -> next cycle sample 0x11112222, level 1.
REQ-033 DEPTH=8: 9 pushes, no consume -> level 8, full 1, overflow 1, ninth value never appears on sample; clr_flags -> overflow 0.
REQ-034 Full FIFO, push and sample_rdy same cycle -> push accepted, level stays 8, overflow stays 0, sample = first entry.
REQ-035 Empty FIFO, sample = 0x0000ABCD: sample_rdy with underflow_zero=0 -> sample 0x0000ABCD, underflow 1; repeat with underflow_zero=1 -> sample 0.
REQ-036 Empty FIFO, push 0x5A5A5A5A and sample_rdy same cycle -> level 1, underflow 1, sample unchanged; next sample_rdy -> sample 0x5A5A5A5A.
REQ-037 Level 5, drop en for one cycle -> level 0, sample 0, irq 0, flags retained; 20 push/consume pairs afterward -> output order matches input across pointer wrap.
